app_width_upsizer: RTL and testbench
====================================

// Module: app_width_upsizer
// PURPOSE
//  Parametrised successor of the 8->16 application loopback: packs IN_WIDTH-bit input-FIFO words into
//  OUT_WIDTH-bit output-FIFO words, LSB lane first. Sits between the high-speed interface FIFOs.
//  Adds backpressure-safe output holding, partial-word flush with padding, and a status byte.
// PARAMETERS
//  IN_WIDTH   8       input word width (bits)
//  OUT_WIDTH  16      output word width; must be an integer multiple of IN_WIDTH, RATIO=OUT_WIDTH/IN_WIDTH in 2..16
//  PAD_WORD   8'h00   lane value inserted on flush (IN_WIDTH bits)
// PORTS
//  CLK         in   1          single clock, all logic posedge
//  RESET_N     in   1          asynchronous, active-low reset
//  din         in   IN_WIDTH   input FIFO data, valid while empty=0 (first-word-fall-through)
//  rd_en       out  1          input FIFO read strobe (combinational)
//  empty       in   1          input FIFO empty
//  dout        out  OUT_WIDTH  packed output word (registered)
//  wr_en       out  1          output FIFO write strobe
//  full        in   1          output FIFO full
//  flush       in   1          one-cycle request: emit pending partial word, padded
//  app_mode    in   8          VCR mode; 8'h00/8'h01 pack, 8'h02 lane-reversed pack (macro), else idle
//  app_status  out  8          [0] out_valid, [1] partial (lane_cnt!=0), [2] flush_pending, [7:3] 0
// BEHAVIOUR
//  Reset (RESET_N=0, async): lane_cnt=0, acc=0, dout=0, out_valid=0, flush_pending=0; rd_en=0, wr_en=0.
//  State: acc (OUT_WIDTH-IN_WIDTH bits), lane_cnt [0..RATIO-1], holding register dout+out_valid.
//  wr_en = out_valid & ~full. out_valid clears on the edge where wr_en=1 unless a new word loads same edge.
//  slot_free = ~out_valid | wr_en. active = app_mode in {00,01} (or 02 with macro).
//  rd_en = ~empty & active & ~flush_pending & (lane_cnt!=RATIO-1 | slot_free).
//  On rd_en edge: lane lane_cnt of acc <= din, lane_cnt++. If lane_cnt==RATIO-1: dout <= {din,acc},
//   out_valid<=1, lane_cnt<=0. Latency: last lane read at edge N -> wr_en high in cycle N+1 if ~full.
//  full held: dout and out_valid frozen; reading continues until lanes 0..RATIO-2 filled, then stalls.
//  Never two words in flight; never a write while full; no word lost or duplicated.
//  flush while lane_cnt==0: ignored. Otherwise set flush_pending; when slot_free, dout <= acc with
//   unfilled lanes = PAD_WORD, out_valid<=1, lane_cnt<=0, flush_pending<=0. rd_en held 0 while pending.
//  flush coincident with a completing rd_en: completing word emitted, flush then ignored (lane_cnt=0).
//  app_mode leaves active mid-word: rd_en=0, acc/lane_cnt retained, resume on re-entry; flush still honoured.
//  Held output word drains regardless of app_mode.
//  Reset mid-word: partial data discarded, no write issued.
// CONFIGURATION
//  APP_WIDTH_UPSIZER_SWAP_EN defined: app_mode 8'h02 is active and packs MSB lane first
//   (first input word lands in dout[OUT_WIDTH-1 -: IN_WIDTH]); padding fills low lanes on flush.
//  Not defined: 8'h02 treated as idle (rd_en=0), no lane-reversal mux synthesised.
// STRUCTURE
//  Package app_pkg: MODE_PACK0=8'h00, MODE_PACK1=8'h01, MODE_SWAP=8'h02, status bit indices
//   ST_OUT_VALID=0, ST_PARTIAL=1, ST_FLUSH_PEND=2.
//  Sub-module app_lane_acc: lane register file + lane_cnt + pad/reverse merge; top holds handshake
//   and output holding register. Elaboration check: OUT_WIDTH % IN_WIDTH == 0 else $error.
// TESTING
//  Defaults, stream 8'h11,22,33,44, full=0 -> writes 16'h2211 then 16'h4433, each one cycle after 2nd lane.
//  OUT_WIDTH=32, 8 bytes 01..08, full held 10 cycles after first word -> rd_en stops after 3 bytes of
//   word 2; dout stays 32'h04030201; on release writes 32'h08070605, exactly 2 writes total.
//  Byte 8'hAB then flush, PAD_WORD=8'h00 -> single write 16'h00AB; app_status[1] returns 0.
//  app_mode 8'h00->8'h07 after 1 byte (8'h5A), 5 idle cycles, back to 8'h00, byte 8'hC3 -> write 16'hC35A.
//  With SWAP_EN, app_mode 8'h02, bytes 8'h11,8'h22 -> 16'h1122; without macro -> rd_en stays 0.
//  RESET_N low mid-word after 8'h77, then bytes 8'h01,8'h02 -> only write 16'h0201; async clear verified.

Source files
------------

// File: rtl/app_pkg.sv
// Package: app_pkg
// Shared constants for app_width_upsizer and its lane accumulator:
//   MODE_*  : app_mode register encodings
//   ST_*    : app_status bit positions
//   mode_active() : whether an app_mode value enables packing
// Optional feature macro: APP_WIDTH_UPSIZER_SWAP_EN (enables MODE_SWAP).
package app_pkg;

  localparam logic [7:0] MODE_PACK0 = 8'h00;
  localparam logic [7:0] MODE_PACK1 = 8'h01;
  localparam logic [7:0] MODE_SWAP  = 8'h02;

  localparam int unsigned ST_OUT_VALID  = 0;
  localparam int unsigned ST_PARTIAL    = 1;
  localparam int unsigned ST_FLUSH_PEND = 2;

  function automatic logic mode_active(input logic [7:0] mode);
`ifdef APP_WIDTH_UPSIZER_SWAP_EN
    return (mode == MODE_PACK0) || (mode == MODE_PACK1) || (mode == MODE_SWAP);
`else
    return (mode == MODE_PACK0) || (mode == MODE_PACK1);
`endif
  endfunction

endpackage

// File: rtl/app_lane_acc.sv
// Module: app_lane_acc
// Lane register file for the width upsizer. Collects IN_WIDTH-bit lanes
// 0..RATIO-2 in acc, tracks the lane count, and presents the merged output
// word: either {din, acc} (word completing on this read) or acc with the
// unfilled lanes replaced by PAD_WORD (flush). With
// APP_WIDTH_UPSIZER_SWAP_EN defined, swap_i reverses lane order so the first
// lane received lands in the most significant lane.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   swap_i         reverse lane order in word_o (macro builds only)
//   load_i         accept din_i into lane lane_cnt_o
//   din_i          input lane data
//   clear_i        restart the word (flush emitted)
//   pad_sel_i      word_o is the padded partial word instead of {din_i, acc}
//   lane_cnt_o     number of lanes currently held
//   word_o         merged output word
module app_lane_acc #(
  parameter int unsigned           IN_WIDTH  = 8,
  parameter int unsigned           OUT_WIDTH = 16,
  parameter logic [IN_WIDTH-1:0]   PAD_WORD  = '0,
  localparam int unsigned          RATIO     = OUT_WIDTH / IN_WIDTH,
  localparam int unsigned          CW        = $clog2(RATIO)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
`ifdef APP_WIDTH_UPSIZER_SWAP_EN
  input  logic                 swap_i,
`endif
  input  logic                 load_i,
  input  logic [IN_WIDTH-1:0]  din_i,
  input  logic                 clear_i,
  input  logic                 pad_sel_i,
  output logic [CW-1:0]        lane_cnt_o,
  output logic [OUT_WIDTH-1:0] word_o
);

  logic [OUT_WIDTH-IN_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]          nat_w;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      if (cnt_q == CW'(RATIO - 1)) begin
        // Last lane goes straight into the output word, not into acc.
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
        for (int unsigned i = 0; i < RATIO - 1; i++) begin
          if (cnt_q == CW'(i)) acc_d[i*IN_WIDTH +: IN_WIDTH] = din_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // Natural (LSB-first) merge; lanes at or above the count are stale and
  // get PAD_WORD on a flush. Lane RATIO-1 is never filled during a flush.
  always_comb begin
    nat_w = {din_i, acc_q};
    if (pad_sel_i) begin
      for (int unsigned i = 0; i < RATIO; i++) begin
        if (CW'(i) >= cnt_q) nat_w[i*IN_WIDTH +: IN_WIDTH] = PAD_WORD;
      end
    end
  end

`ifdef APP_WIDTH_UPSIZER_SWAP_EN
  always_comb begin
    word_o = nat_w;
    if (swap_i) begin
      for (int unsigned j = 0; j < RATIO; j++) begin
        word_o[j*IN_WIDTH +: IN_WIDTH] = nat_w[(RATIO-1-j)*IN_WIDTH +: IN_WIDTH];
      end
    end
  end
`else
  assign word_o = nat_w;
`endif

  assign lane_cnt_o = cnt_q;

endmodule

// File: rtl/app_width_upsizer.sv
// Module: app_width_upsizer
// Packs IN_WIDTH-bit words from a first-word-fall-through input FIFO into
// OUT_WIDTH-bit words for an output FIFO, LSB lane first. One registered
// output word is held until the output FIFO accepts it; a flush request
// emits the pending partial word padded with PAD_WORD.
// Ports:
//   CLK, RESET_N  clock, asynchronous active-low reset
//   din, empty    input FIFO data / empty; rd_en is the (combinational) pop
//   dout, wr_en   output word (registered) and write strobe; full stalls it
//   flush         one-cycle request to emit the partial word
//   app_mode      00/01 pack, 02 lane-reversed pack (macro builds), else idle
//   app_status    [0] out_valid, [1] partial word held, [2] flush pending
// Optional feature macro: APP_WIDTH_UPSIZER_SWAP_EN.
module app_width_upsizer
  import app_pkg::*;
#(
  parameter int unsigned         IN_WIDTH  = 8,
  parameter int unsigned         OUT_WIDTH = 16,
  parameter logic [IN_WIDTH-1:0] PAD_WORD  = '0
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [IN_WIDTH-1:0]  din,
  output logic                 rd_en,
  input  logic                 empty,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 wr_en,
  input  logic                 full,
  input  logic                 flush,
  input  logic [7:0]           app_mode,
  output logic [7:0]           app_status
);

  localparam int unsigned RATIO = OUT_WIDTH / IN_WIDTH;
  localparam int unsigned CW    = $clog2(RATIO);

  if ((OUT_WIDTH % IN_WIDTH) != 0 || RATIO < 2 || RATIO > 16) begin : g_bad_cfg
    $error("app_width_upsizer: OUT_WIDTH must be IN_WIDTH times 2..16");
  end

  logic [OUT_WIDTH-1:0] dout_q, dout_d;
  logic                 out_valid_q, out_valid_d;
  logic                 pend_q, pend_d;
  logic [CW-1:0]        lane_cnt;
  logic [OUT_WIDTH-1:0] word;
  logic                 slot_free, active, last_lane, partial;
  logic                 complete, emit_flush, load;

  assign wr_en     = out_valid_q & ~full;
  assign slot_free = ~out_valid_q | wr_en;
  assign active    = mode_active(app_mode);
  assign last_lane = (lane_cnt == CW'(RATIO - 1));
  assign partial   = (lane_cnt != '0);

  // RESET_N gates the strobe so nothing is popped while in reset.
  assign rd_en      = RESET_N & ~empty & active & ~pend_q & (~last_lane | slot_free);
  assign complete   = rd_en & last_lane;
  assign emit_flush = pend_q & slot_free;
  assign load       = complete | emit_flush;

`ifdef APP_WIDTH_UPSIZER_SWAP_EN
  logic swap;
  assign swap = (app_mode == MODE_SWAP);
`endif

  app_lane_acc #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .PAD_WORD (PAD_WORD)
  ) u_lane_acc (
    .clk_i     (CLK),
    .rst_ni    (RESET_N),
`ifdef APP_WIDTH_UPSIZER_SWAP_EN
    .swap_i    (swap),
`endif
    .load_i    (rd_en),
    .din_i     (din),
    .clear_i   (emit_flush),
    .pad_sel_i (pend_q),
    .lane_cnt_o(lane_cnt),
    .word_o    (word)
  );

  always_comb begin
    dout_d      = load ? word : dout_q;
    out_valid_d = load | (out_valid_q & ~wr_en);
    // A flush landing on the completing read finds nothing left to pad.
    if (emit_flush)                      pend_d = 1'b0;
    else if (flush & partial & ~complete) pend_d = 1'b1;
    else                                  pend_d = pend_q;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      pend_q      <= pend_d;
    end
  end

  assign dout = dout_q;

  always_comb begin
    app_status                = '0;
    app_status[ST_OUT_VALID]  = out_valid_q;
    app_status[ST_PARTIAL]    = partial;
    app_status[ST_FLUSH_PEND] = pend_q;
  end

endmodule

// File: tb/tb_app_width_upsizer.sv
module tb_app_width_upsizer;

  localparam int RA = 2;
  localparam logic [7:0] PAD_A = 8'h00;
`ifdef APP_WIDTH_UPSIZER_SWAP_EN
  localparam bit SWAP_EN = 1'b1;
`else
  localparam bit SWAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [7:0]  din_a, mode_a, status_a;
  logic        empty_a, rd_en_a, wr_en_a, full_a, flush_a;
  logic [15:0] dout_a;

  logic [7:0]  din_b, mode_b, status_b;
  logic        empty_b, rd_en_b, wr_en_b, full_b, flush_b;
  logic [31:0] dout_b;

  app_width_upsizer #(.IN_WIDTH(8), .OUT_WIDTH(16), .PAD_WORD(PAD_A)) u_dut_a (
    .CLK(clk), .RESET_N(rst_n), .din(din_a), .rd_en(rd_en_a), .empty(empty_a),
    .dout(dout_a), .wr_en(wr_en_a), .full(full_a), .flush(flush_a),
    .app_mode(mode_a), .app_status(status_a));

  app_width_upsizer #(.IN_WIDTH(8), .OUT_WIDTH(32), .PAD_WORD(8'hEE)) u_dut_b (
    .CLK(clk), .RESET_N(rst_n), .din(din_b), .rd_en(rd_en_b), .empty(empty_b),
    .dout(dout_b), .wr_en(wr_en_b), .full(full_b), .flush(flush_b),
    .app_mode(mode_b), .app_status(status_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Input FIFO contents for both DUTs
  logic [7:0] src_a[$];
  logic [7:0] src_b[$];
  int nreads_b = 0;

  task automatic refresh();
    empty_a = (src_a.size() == 0);
    din_a   = empty_a ? 8'($urandom) : src_a[0];
    empty_b = (src_b.size() == 0);
    din_b   = empty_b ? 8'($urandom) : src_b[0];
  endtask

  task automatic cycle();
    logic pa, pb;
    @(negedge clk);
    pa = rd_en_a & ~empty_a;
    pb = rd_en_b & ~empty_b;
    @(posedge clk);
    #1;
    if (pa) void'(src_a.pop_front());
    if (pb) begin
      void'(src_b.pop_front());
      nreads_b++;
    end
    flush_a = 1'b0;
    flush_b = 1'b0;
    refresh();
  endtask

  // Reference model for DUT A: lanes collected so far, one-deep output
  // holding slot as a queue, flush request latch.
  logic [7:0]  lanes_m [RA];
  int          cnt_m = 0;
  bit          pend_m = 0;
  logic [15:0] held_q[$];
  logic [15:0] wlog_m[$];
  logic [15:0] log_a[$];
  logic [31:0] log_b[$];

  function automatic logic [15:0] pack_a(input int n, input bit swap);
    logic [15:0] w;
    logic [7:0]  v;
    w = '0;
    for (int i = 0; i < RA; i++) begin
      v = (i < n) ? lanes_m[i] : PAD_A;
      if (swap) w[(RA-1-i)*8 +: 8] = v;
      else      w[i*8 +: 8] = v;
    end
    return w;
  endfunction

  bit m_act, m_held, m_wr, m_free, m_last, m_rd, m_swap;
  int m_cnt0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_rd_en", 32'(rd_en_a), 32'd0);
      chk("reset_wr_en", 32'(wr_en_a), 32'd0);
      chk("reset_dout", 32'(dout_a), 32'd0);
      chk("reset_status", 32'(status_a), 32'd0);
      cnt_m  = 0;
      pend_m = 0;
      held_q.delete();
    end else begin
      m_act  = (mode_a == 8'h00) || (mode_a == 8'h01) || (SWAP_EN && mode_a == 8'h02);
      m_swap = SWAP_EN && (mode_a == 8'h02);
      m_held = (held_q.size() != 0);
      m_wr   = m_held && !full_a;
      m_free = !m_held || m_wr;
      m_last = (cnt_m == RA - 1);
      m_rd   = !empty_a && m_act && !pend_m && (!m_last || m_free);
      chk("rd_en", 32'(rd_en_a), 32'(m_rd));
      chk("wr_en", 32'(wr_en_a), 32'(m_wr));
      if (m_held) chk("dout", 32'(dout_a), 32'(held_q[0]));
      chk("status", 32'(status_a), 32'({5'b0, pend_m, (cnt_m != 0), m_held}));
      if (wr_en_a) log_a.push_back(dout_a);
      m_cnt0 = cnt_m;
      if (m_wr) wlog_m.push_back(held_q.pop_front());
      if (m_rd) begin
        lanes_m[cnt_m] = din_a;
        if (m_last) begin
          held_q.push_back(pack_a(RA, m_swap));
          cnt_m = 0;
        end else begin
          cnt_m++;
        end
      end
      if (pend_m && m_free) begin
        held_q.push_back(pack_a(cnt_m, m_swap));
        cnt_m  = 0;
        pend_m = 0;
      end else if (flush_a && m_cnt0 != 0 && !(m_rd && m_last)) begin
        pend_m = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && wr_en_b) begin
      chk("b_write_while_full", 32'(full_b), 32'd0);
      log_b.push_back(dout_b);
    end
  end

  int  r;
  bit  seen;

  initial begin
    rst_n = 1'b0;
    full_a = 0; flush_a = 0; mode_a = 8'h00;
    full_b = 0; flush_b = 0; mode_b = 8'h00;
    refresh();
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    // Basic 8->16 stream
    log_a.delete();
    src_a.push_back(8'h11); src_a.push_back(8'h22);
    src_a.push_back(8'h33); src_a.push_back(8'h44);
    refresh();
    repeat (8) cycle();
    chk("t1_writes", 32'(log_a.size()), 32'd2);
    if (log_a.size() == 2) begin
      chk("t1_word0", 32'(log_a[0]), 32'h2211);
      chk("t1_word1", 32'(log_a[1]), 32'h4433);
    end

    // Partial word flush with zero padding
    log_a.delete();
    src_a.push_back(8'hAB);
    refresh();
    cycle();
    flush_a = 1'b1;
    cycle();
    repeat (4) cycle();
    chk("t3_writes", 32'(log_a.size()), 32'd1);
    if (log_a.size() == 1) chk("t3_word", 32'(log_a[0]), 32'h00AB);
    chk("t3_partial", 32'(status_a[1]), 32'd0);

    // Leave active mode mid-word and resume
    log_a.delete();
    src_a.push_back(8'h5A);
    refresh();
    cycle();
    mode_a = 8'h07;
    src_a.push_back(8'hC3);
    refresh();
    repeat (5) cycle();
    chk("t4_idle_no_read", 32'(src_a.size()), 32'd1);
    mode_a = 8'h00;
    repeat (4) cycle();
    chk("t4_writes", 32'(log_a.size()), 32'd1);
    if (log_a.size() == 1) chk("t4_word", 32'(log_a[0]), 32'hC35A);

    // Lane-reversed mode
    log_a.delete();
    mode_a = 8'h02;
    src_a.push_back(8'h11); src_a.push_back(8'h22);
    refresh();
    repeat (6) cycle();
    if (SWAP_EN) begin
      chk("t5_writes", 32'(log_a.size()), 32'd1);
      if (log_a.size() == 1) chk("t5_word", 32'(log_a[0]), 32'h1122);
    end else begin
      chk("t5_no_read", 32'(src_a.size()), 32'd2);
      chk("t5_no_write", 32'(log_a.size()), 32'd0);
    end
    mode_a = 8'h00;
    repeat (5) cycle();

    // Reset mid-word
    log_a.delete();
    src_a.push_back(8'h77);
    refresh();
    cycle();
    chk("t6_partial_before", 32'(status_a[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_status", 32'(status_a), 32'd0);
    chk("t6_async_dout", 32'(dout_a), 32'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    src_a.push_back(8'h01); src_a.push_back(8'h02);
    refresh();
    repeat (6) cycle();
    chk("t6_writes", 32'(log_a.size()), 32'd1);
    if (log_a.size() == 1) chk("t6_word", 32'(log_a[0]), 32'h0201);

    // 8->32 with backpressure on the first word
    log_b.delete();
    nreads_b = 0;
    for (int i = 1; i <= 8; i++) src_b.push_back(8'(i));
    refresh();
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (status_b[0]) seen = 1;
    end
    chk("b_first_word_ready", 32'(seen), 32'd1);
    full_b = 1'b1;
    repeat (10) cycle();
    chk("b_reads_stalled", 32'(nreads_b), 32'd7);
    chk("b_rd_en_low", 32'(rd_en_b), 32'd0);
    chk("b_dout_held", dout_b, 32'h04030201);
    chk("b_no_write_held", 32'(log_b.size()), 32'd0);
    full_b = 1'b0;
    repeat (10) cycle();
    chk("b_writes", 32'(log_b.size()), 32'd2);
    if (log_b.size() == 2) begin
      chk("b_word0", log_b[0], 32'h04030201);
      chk("b_word1", log_b[1], 32'h08070605);
    end

    // 8->32 flush with non-zero pad
    log_b.delete();
    src_b.push_back(8'h05);
    refresh();
    cycle();
    flush_b = 1'b1;
    cycle();
    repeat (4) cycle();
    chk("b_flush_writes", 32'(log_b.size()), 32'd1);
    if (log_b.size() == 1) chk("b_flush_word", log_b[0], 32'hEEEEEE05);

    // Random traffic on DUT A against the model
    log_a.delete();
    wlog_m.delete();
    for (int n = 0; n < 3000; n++) begin
      if (src_a.size() < 3 && $urandom_range(0, 2) != 0) src_a.push_back(8'($urandom));
      full_a  = ($urandom_range(0, 3) == 0);
      flush_a = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 39) == 0) begin
        r = $urandom_range(0, 4);
        mode_a = (r == 0) ? 8'h01 : (r == 1) ? 8'h02 : (r == 2) ? 8'h07 : 8'h00;
      end
      refresh();
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
      end else begin
        cycle();
      end
    end
    full_a = 1'b0;
    mode_a = 8'h00;
    repeat (10) cycle();
    chk("rand_write_count", 32'(log_a.size()), 32'(wlog_m.size()));
    chk("rand_enough_writes", 32'(wlog_m.size() > 200), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
